mac4_producer: RTL and testbench
================================

# mac4_producer

Four-lane signed multiply-accumulate engine that generates the 4-lane result bundle and one-cycle ready strobe consumed by the ReLU stage. A single activation stream is broadcast across four weight lanes, one per output neuron. Each lane accumulates N_TERMS products, then presents all four sums with a single-cycle `out_ready` pulse, matching the ReLU input contract: `in_ready` plus `in0`..`in3`, with no backpressure.

## Interface
- DATA_W, 8: signed width of activation and weights
- ACC_W, 21: signed accumulator/output width; must equal the downstream RELU_SIZE
- N_TERMS, 16: products accumulated per result; legal range 1..255
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new accumulation; sampled only in IDLE
- in_valid  in  1  x/w0..w3 carry a valid term this cycle
- x  in  DATA_W  signed activation, broadcast to all lanes
- w0, w1, w2, w3  in  DATA_W each  signed per-lane weights
- busy  out  1  high while in ACC
- out_ready  out  1  one-cycle strobe; connects to downstream in_ready
- out0, out1, out2, out3  out  ACC_W each  signed lane results; connect to downstream in0..in3

## Operation
- States:
  - IDLE: `busy`=0. `start`=1 clears acc0..acc3 and the term counter, then moves to ACC. `in_valid` is ignored.
  - ACC: `busy`=1. Each cycle with `in_valid`=1, acc_i <= sat(acc_i + sext(x*w_i)) and count increments. Cycles with `in_valid`=0 hold all state.
  - Leaving ACC: when the accepted term is term N_TERMS (count == N_TERMS-1 and `in_valid`), on that same edge:
    - out_i load the saturated final sums.
    - `out_ready` is set.
    - State returns to IDLE.
- `start` in ACC is ignored. It does not restart the accumulation.
- Arithmetic:
  - Each product is a full 2*DATA_W signed result, sign-extended to ACC_W.
  - Each addition saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Saturation is sticky only in the sense that later terms are added to the clamped value.
- out0..out3 are registered. They change only on a completion edge and hold between results.
- Counter width is 8 bits.
- Reset mid-accumulation: the partial sums are discarded, no `out_ready` is issued, and out_i are cleared.

## Timing
- Reset values: `busy`=0, `out_ready`=0, out0..out3=0, state=IDLE, count=0, acc0..acc3=0.
- `start` sampled at cycle S. `busy`=1 from S+1. The first term can be accepted at S+1.
- `in_valid` coincident with `start` in IDLE is dropped.
- Last term accepted at cycle T:
  - `out_ready`=1 and out_i valid during T+1 only.
  - `busy`=0 from T+1.
- Back-to-back operation: `start` may be asserted in T+1, the `out_ready` cycle. Minimum period per result is N_TERMS+1 cycles.
- `out_ready` is never high for two consecutive cycles.
- No backpressure: the consumer must sample on the strobe.

## Test plan
- Basic (N_TERMS=4): start, then 4 terms with x=2 and w0..w3 = 1, -1, 3, 0.
  - out = 8, -8, 24, 0.
  - `out_ready` high exactly one cycle, the cycle after the 4th term.
- Bubbles: same stimulus with `in_valid` low on 3 interleaved cycles.
  - Identical results.
  - `out_ready` delayed by exactly 3 cycles.
- Saturation (N_TERMS=255, x=-128, w0=-128, w1=127, ACC_W=21):
  - out0 = 1048575 (positive clamp).
  - out1 = -1048576 (negative clamp).
- Ignored controls:
  - `start` pulsed mid-ACC does not change the sums.
  - `in_valid` in IDLE does not change out_i.
- Reset mid-op: rst after 2 of 4 terms.
  - All outputs 0, `busy`=0, no `out_ready`.
  - A following full run yields correct sums.
- Back-to-back: second `start` in the `out_ready` cycle.
  - Second result is correct.
  - First result is held on out_i until the second strobe.

Source files
------------

// File: rtl/mac4_producer.sv
// mac4_producer: four-lane signed multiply-accumulate feeding the ReLU stage.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               begin a new accumulation (sampled only when idle)
//   in_valid            x/w0..w3 carry a valid term this cycle
//   x                   signed activation broadcast to all lanes
//   w0..w3              signed per-lane weights
//   busy                high while accumulating
//   out_ready           one-cycle strobe when out0..out3 carry a new result
//   out0..out3          registered, saturated signed lane results
module mac4_producer #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 21,
    parameter int N_TERMS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w0,
    input  logic [DATA_W-1:0] w1,
    input  logic [DATA_W-1:0] w2,
    input  logic [DATA_W-1:0] w3,
    output logic              busy,
    output logic              out_ready,
    output logic [ACC_W-1:0]  out0,
    output logic [ACC_W-1:0]  out1,
    output logic [ACC_W-1:0]  out2,
    output logic [ACC_W-1:0]  out3
);
    typedef enum logic {IDLE, ACC} state_t;
    state_t            state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic              out_ready_q, out_ready_d;
    logic [ACC_W-1:0]  acc_q [4];
    logic [ACC_W-1:0]  acc_d [4];
    logic [ACC_W-1:0]  out_q [4];
    logic [ACC_W-1:0]  out_d [4];
    logic [ACC_W-1:0]  sum   [4];

    // One extra guard bit: overflow shows as the top two bits disagreeing,
    // and the top bit then gives the direction of the clamp.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [DATA_W-1:0] xv,
                                                 input logic [DATA_W-1:0] wv);
        logic signed [2*DATA_W-1:0] p;
        logic [ACC_W:0]             s;
        p = $signed(xv) * $signed(wv);
        s = {a[ACC_W-1], a} + {{(ACC_W+1-2*DATA_W){p[2*DATA_W-1]}}, p};
        return (s[ACC_W] != s[ACC_W-1]) ? {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}} : s[ACC_W-1:0];
    endfunction

    always_comb begin
        sum[0] = sat_add(acc_q[0], x, w0);
        sum[1] = sat_add(acc_q[1], x, w1);
        sum[2] = sat_add(acc_q[2], x, w2);
        sum[3] = sat_add(acc_q[3], x, w3);
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_ready_d = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = ACC;
                count_d = '0;
                acc_d   = '{default: '0};
            end
        end else if (in_valid) begin
            acc_d   = sum;
            count_d = count_q + 8'd1;
            if (count_q == 8'(N_TERMS - 1)) begin
                out_d       = sum;
                out_ready_d = 1'b1;
                state_d     = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            out_ready_q <= 1'b0;
            acc_q       <= '{default: '0};
            out_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_ready_q <= out_ready_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
        end
    end

    assign busy      = (state_q == ACC);
    assign out_ready = out_ready_q;
    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
endmodule

// File: tb/tb_mac4_producer.sv
// tb_mac4_producer: self-checking bench for mac4_producer (N_TERMS=4 and 255 instances).
module tb_mac4_producer;
    localparam longint HI = 1048575;
    localparam longint LO = -1048576;

    logic clk = 1'b0;
    logic rst, start4, start255, in_valid;
    logic signed [7:0] x, w0, w1, w2, w3;
    logic busy4, rdy4, busy255, rdy255;
    logic [20:0] a0, a1, a2, a3, b0, b1, b2, b3;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int c0;

    logic signed [7:0] tx [256];
    logic signed [7:0] tw [256][4];
    int     bub [256];
    bit     st  [256];
    longint held [2][4];

    typedef struct packed {
        logic signed [7:0]  x, w0, w1, w2, w3;
        logic signed [31:0] e0, e1, e2, e3;
    } vec_t;
    vec_t vt [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac4_producer #(.DATA_W(8), .ACC_W(21), .N_TERMS(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .x(x),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .busy(busy4), .out_ready(rdy4),
        .out0(a0), .out1(a1), .out2(a2), .out3(a3));

    mac4_producer #(.DATA_W(8), .ACC_W(21), .N_TERMS(255)) u255 (
        .clk(clk), .rst(rst), .start(start255), .in_valid(in_valid), .x(x),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .busy(busy255), .out_ready(rdy255),
        .out0(b0), .out1(b1), .out2(b2), .out3(b3));

    task automatic chk(input string nm, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint lane(input bit s, input int i);
        logic [20:0] v;
        v = s ? (i == 0 ? b0 : i == 1 ? b1 : i == 2 ? b2 : b3)
              : (i == 0 ? a0 : i == 1 ? a1 : i == 2 ? a2 : a3);
        return longint'($signed(v));
    endfunction

    function automatic longint rdy(input bit s);  return s ? longint'(rdy255) : longint'(rdy4); endfunction
    function automatic longint busy(input bit s); return s ? longint'(busy255) : longint'(busy4); endfunction

    // Reference: running sum of products, clamped to the 21-bit range after every term.
    function automatic longint model(input int n, input int i);
        longint acc = 0;
        for (int k = 0; k < n; k++) begin
            acc += longint'(tx[k]) * longint'(tw[k][i]);
            acc = acc > HI ? HI : acc < LO ? LO : acc;
        end
        return acc;
    endfunction

    task automatic drive(input bit v, input logic signed [7:0] xv, input logic signed [7:0] wv [4]);
        in_valid = v; x = xv; w0 = wv[0]; w1 = wv[1]; w2 = wv[2]; w3 = wv[3];
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic begin_op(input bit s);
        logic signed [7:0] junk [4];
        junk = '{8'sd100, 8'sd100, 8'sd100, 8'sd100};
        start4 = !s; start255 = s;
        drive(1'b1, 8'sd100, junk);
        tick();
        start4 = 1'b0; start255 = 1'b0; in_valid = 1'b0;
        c0 = cyc;
        chk("busy_after_start", busy(s), 1);
    endtask

    task automatic acc_cycle_check(input bit s);
        chk("ready_low_in_acc", rdy(s), 0);
        chk("busy_in_acc", busy(s), 1);
        for (int i = 0; i < 4; i++) chk("out_held_in_acc", lane(s, i), held[s][i]);
    endtask

    task automatic feed(input bit s, input int n);
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < bub[k]; b++) begin
                in_valid = 1'b0;
                acc_cycle_check(s);
                tick();
            end
            drive(1'b1, tx[k], tw[k]);
            start4 = st[k] && !s; start255 = st[k] && s;
            acc_cycle_check(s);
            tick();
        end
        in_valid = 1'b0; start4 = 1'b0; start255 = 1'b0;
    endtask

    task automatic complete_check(input bit s, input int n);
        int nb = 0;
        for (int k = 0; k < n; k++) nb += bub[k];
        chk("ready_strobe", rdy(s), 1);
        chk("busy_after_done", busy(s), 0);
        chk("latency", longint'(cyc - c0), longint'(n + nb));
        for (int i = 0; i < 4; i++) begin
            held[s][i] = model(n, i);
            chk("result", lane(s, i), held[s][i]);
        end
    endtask

    task automatic post_check(input bit s);
        tick();
        chk("ready_single_cycle", rdy(s), 0);
        for (int i = 0; i < 4; i++) chk("out_held_after", lane(s, i), held[s][i]);
    endtask

    task automatic fill_const(input int n, input logic signed [7:0] xv, input logic signed [7:0] wv [4]);
        for (int k = 0; k < n; k++) begin
            tx[k] = xv; tw[k] = wv; bub[k] = 0; st[k] = 1'b0;
        end
    endtask

    task automatic fill_rand(input int n);
        for (int k = 0; k < n; k++) begin
            tx[k] = 8'($urandom);
            for (int i = 0; i < 4; i++) tw[k][i] = 8'($urandom);
            bub[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            st[k]  = ($urandom_range(0, 4) == 0);
        end
    endtask

    initial begin
        logic signed [7:0] wv [4];
        rst = 1'b1; start4 = 1'b0; start255 = 1'b0; in_valid = 1'b0;
        x = '0; w0 = '0; w1 = '0; w2 = '0; w3 = '0;
        held = '{default: 0};
        vt[0] = '{8'sd2,   8'sd1,   -8'sd1,  8'sd3,   8'sd0,   32'sd8,     -32'sd8,     32'sd24,     32'sd0};
        vt[1] = '{8'h80,   8'h80,   8'sd127, 8'h80,   8'sd1,   32'sd65536, -32'sd65024, 32'sd65536,  -32'sd512};
        vt[2] = '{8'sd127, 8'sd127, 8'sd127, -8'sd1,  8'sd0,   32'sd64516, 32'sd64516,  -32'sd508,   32'sd0};
        vt[3] = '{-8'sd3,  8'sd5,   8'sd0,   -8'sd7,  8'sd100, -32'sd60,   32'sd0,      32'sd84,     -32'sd1200};
        tick(); tick();
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            chk("reset_busy", busy(1'(s)), 0);
            chk("reset_ready", rdy(1'(s)), 0);
            for (int i = 0; i < 4; i++) chk("reset_out", lane(1'(s), i), 0);
        end

        for (int v = 0; v < 4; v++) begin
            wv = '{vt[v].w0, vt[v].w1, vt[v].w2, vt[v].w3};
            fill_const(4, vt[v].x, wv);
            begin_op(1'b0); feed(1'b0, 4); complete_check(1'b0, 4);
            chk("table_out0", lane(1'b0, 0), longint'(vt[v].e0));
            chk("table_out1", lane(1'b0, 1), longint'(vt[v].e1));
            chk("table_out2", lane(1'b0, 2), longint'(vt[v].e2));
            chk("table_out3", lane(1'b0, 3), longint'(vt[v].e3));
            post_check(1'b0);
        end

        wv = '{8'sd1, -8'sd1, 8'sd3, 8'sd0};
        fill_const(4, 8'sd2, wv);
        bub[1] = 1; bub[2] = 1; bub[3] = 1;
        begin_op(1'b0); feed(1'b0, 4); complete_check(1'b0, 4);
        chk("bubble_out0", lane(1'b0, 0), 8);
        chk("bubble_out1", lane(1'b0, 1), -8);
        post_check(1'b0);

        fill_const(4, 8'sd2, wv);
        st[1] = 1'b1; st[2] = 1'b1;
        begin_op(1'b0); feed(1'b0, 4); complete_check(1'b0, 4);
        chk("midstart_out2", lane(1'b0, 2), 24);
        post_check(1'b0);

        for (int c = 0; c < 3; c++) begin
            wv = '{8'sd9, 8'sd9, 8'sd9, 8'sd9};
            drive(1'b1, 8'sd7, wv);
            tick();
            chk("idle_valid_ready", rdy(1'b0), 0);
            chk("idle_valid_busy", busy(1'b0), 0);
            for (int i = 0; i < 4; i++) chk("idle_valid_out", lane(1'b0, i), held[0][i]);
        end
        in_valid = 1'b0;

        fill_rand(4);
        for (int k = 0; k < 4; k++) begin bub[k] = 0; st[k] = 1'b0; end
        begin_op(1'b0); feed(1'b0, 2);
        rst = 1'b1; tick(); rst = 1'b0;
        held[0] = '{default: 0}; held[1] = '{default: 0};
        for (int c = 0; c < 3; c++) begin
            chk("rst_mid_busy", busy(1'b0), 0);
            chk("rst_mid_ready", rdy(1'b0), 0);
            for (int i = 0; i < 4; i++) chk("rst_mid_out", lane(1'b0, i), 0);
            tick();
        end
        begin_op(1'b0); feed(1'b0, 4); complete_check(1'b0, 4); post_check(1'b0);

        wv = '{8'h80, 8'sd127, 8'sd55, 8'sd1};
        fill_const(255, 8'h80, wv);
        begin_op(1'b1); feed(1'b1, 255); complete_check(1'b1, 255);
        chk("sat_pos_out0", lane(1'b1, 0), 1048575);
        chk("sat_neg_out1", lane(1'b1, 1), -1048576);
        post_check(1'b1);

        for (int r = 0; r < 10; r++) begin
            fill_rand(4);
            begin_op(1'b0); feed(1'b0, 4); complete_check(1'b0, 4);
            if (r % 3 == 2) begin
                fill_rand(4);
                begin_op(1'b0);
                chk("b2b_held_first", lane(1'b0, 3), held[0][3]);
                feed(1'b0, 4); complete_check(1'b0, 4);
            end
            post_check(1'b0);
        end

        for (int k = 0; k < 255; k++) begin
            tx[k] = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'sd127;
            tw[k] = '{8'($urandom), 8'($urandom), 8'h80, 8'sd127};
            bub[k] = 0; st[k] = 1'b0;
        end
        begin_op(1'b1); feed(1'b1, 255); complete_check(1'b1, 255); post_check(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
